// File: rtl/handshake_protocol_monitor.sv
// -----------------------------------------------------------------------------
// handshake_protocol_monitor
//
// Passive checker for N_CH independent valid/ready channels. For every
// channel it tracks the handshake state, counts completed transfers and
// raises sticky flags for three protocol violations:
//   - valid dropped while a transfer was stalled
//   - payload changed while a transfer was stalled
//   - a stall lasted TIMEOUT cycles
// The monitor only observes. It never drives a signal back into the DUT.
//
// Parameters
//   N_CH     number of monitored channels (>= 1)
//   DATA_W   payload width per channel (>= 1)
//   TIMEOUT  stall cycles before the timeout flag sets (2 .. 2**CNT_W-1)
//   CNT_W    width of the per-channel transfer and stall counters
//
// Ports
//   CLK          in   clock, rising edge
//   ASYNCRESET   in   asynchronous active-high reset
//   clear        in   synchronous clear of transfer counters and sticky flags
//   valid        in   [N_CH]          per-channel valid
//   ready        in   [N_CH]          per-channel ready
//   data         in   [N_CH*DATA_W]   payload, channel i at [i*DATA_W +: DATA_W]
//   xfer_count   out  [N_CH*CNT_W]    saturating transfer count per channel
//   err_drop     out  [N_CH]          sticky, valid fell before ready
//   err_data     out  [N_CH]          sticky, payload moved while stalled
//   err_timeout  out  [N_CH]          sticky, stall reached TIMEOUT cycles
//   err_any      out                  OR of every err_* bit
//
// Build option
//   MONITOR_ASSERT_EN  when defined, adds per-channel concurrent assertions
//                      that report each violation through $error. The flag
//                      and counter outputs are identical in both builds.
//
// Per-channel FSM
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | no transfer outstanding
//   PEND    | valid seen without ready, payload snapshot held, stall counting
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module handshake_protocol_monitor #(
    parameter int N_CH    = 3,
    parameter int DATA_W  = 5,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic                     CLK,
    input  logic                     ASYNCRESET,
    input  logic                     clear,
    input  logic [N_CH-1:0]          valid,
    input  logic [N_CH-1:0]          ready,
    input  logic [N_CH*DATA_W-1:0]   data,
    output logic [N_CH*CNT_W-1:0]    xfer_count,
    output logic [N_CH-1:0]          err_drop,
    output logic [N_CH-1:0]          err_data,
    output logic [N_CH-1:0]          err_timeout,
    output logic                     err_any
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } ch_state_e;

    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] STALL_LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] STALL_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch

        logic              v;
        logic              r;
        logic [DATA_W-1:0] d;

        ch_state_e         state_q;
        ch_state_e         state_d;
        logic [CNT_W-1:0]  stall_q;
        logic [CNT_W-1:0]  stall_d;
        logic [CNT_W-1:0]  count_q;
        logic [CNT_W-1:0]  count_d;
        logic [DATA_W-1:0] snap_q;
        logic [DATA_W-1:0] snap_d;
        logic              drop_q;
        logic              data_err_q;
        logic              tmo_q;

        logic              ev_xfer;
        logic              ev_drop;
        logic              ev_data;
        logic              ev_tmo;

        // Only a clean 1 counts as asserted, so X/Z on valid or ready in
        // simulation falls into the "deasserted" branches below.
        assign v = (valid[i] === 1'b1);
        assign r = (ready[i] === 1'b1);
        assign d = data[i*DATA_W +: DATA_W];

        always_comb begin
            state_d = state_q;
            stall_d = stall_q;
            snap_d  = snap_q;
            ev_xfer = v && r;
            ev_drop = 1'b0;
            ev_data = 1'b0;
            ev_tmo  = 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (v && !r) begin
                        state_d = ST_PEND;
                        snap_d  = d;
                        stall_d = CNT_ONE;
                    end
                end
                ST_PEND: begin
                    if (!v) begin
                        ev_drop = 1'b1;
                        state_d = ST_IDLE;
                        stall_d = '0;
                    end else begin
                        // The snapshot is never refreshed while pending, so a
                        // payload that moves and comes back still counts once.
                        ev_data = (d != snap_q);
                        if (r) begin
                            state_d = ST_IDLE;
                            stall_d = '0;
                        end else if (stall_q != STALL_LIMIT) begin
                            stall_d = stall_q + CNT_ONE;
                            // Fires only on the step into TIMEOUT; once
                            // saturated the counter stops and so does this.
                            ev_tmo  = (stall_q == STALL_LAST);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    stall_d = '0;
                end
            endcase

            // An event that lands in the clear cycle survives the clear.
            if (clear) begin
                count_d = CNT_W'(ev_xfer);
            end else if (ev_xfer && (count_q != CNT_MAX)) begin
                count_d = count_q + CNT_ONE;
            end else begin
                count_d = count_q;
            end
        end

        always_ff @(posedge CLK or posedge ASYNCRESET) begin
            if (ASYNCRESET) begin
                state_q    <= ST_IDLE;
                stall_q    <= '0;
                snap_q     <= '0;
                count_q    <= '0;
                drop_q     <= 1'b0;
                data_err_q <= 1'b0;
                tmo_q      <= 1'b0;
            end else begin
                state_q    <= state_d;
                stall_q    <= stall_d;
                snap_q     <= snap_d;
                count_q    <= count_d;
                drop_q     <= ev_drop | (drop_q     & ~clear);
                data_err_q <= ev_data | (data_err_q & ~clear);
                tmo_q      <= ev_tmo  | (tmo_q      & ~clear);
            end
        end

        assign xfer_count[i*CNT_W +: CNT_W] = count_q;
        assign err_drop[i]                  = drop_q;
        assign err_data[i]                  = data_err_q;
        assign err_timeout[i]               = tmo_q;

`ifdef MONITOR_ASSERT_EN
        a_valid_held : assert property (
            @(posedge CLK) disable iff (ASYNCRESET)
            (valid[i] && !ready[i]) |=> valid[i]
        ) else $error("handshake monitor ch %0d: valid dropped while stalled at %0t", i, $time);

        a_data_stable : assert property (
            @(posedge CLK) disable iff (ASYNCRESET)
            (valid[i] && !ready[i]) |=> $stable(data[i*DATA_W +: DATA_W])
        ) else $error("handshake monitor ch %0d: data changed while stalled at %0t", i, $time);

        // The stall counter holds TIMEOUT-1 during the TIMEOUT-th consecutive
        // stalled cycle, so this fires exactly once per stall episode.
        a_no_timeout : assert property (
            @(posedge CLK) disable iff (ASYNCRESET)
            (valid[i] && !ready[i]) |-> (stall_q != STALL_LAST)
        ) else $error("handshake monitor ch %0d: stall reached timeout at %0t", i, $time);
`else
        // Assertions not built; the flag registers above remain the only report.
`endif

    end : g_ch

    assign err_any = |{err_drop, err_data, err_timeout};

endmodule : handshake_protocol_monitor
